// File: rtl/pipeline_if_pkg.sv
// pipeline_if_pkg -- shared definitions for the instruction-fetch stage.
//   PCSrc encodings, fixed vectors (reset / illegal-op / exception),
//   fetch FSM state type, IF/ID payload struct and the kernel-safe
//   PC increment helper.
package pipeline_if_pkg;

  localparam logic [2:0] PCSRC_SEQ   = 3'd0;
  localparam logic [2:0] PCSRC_BR    = 3'd1;
  localparam logic [2:0] PCSRC_J     = 3'd2;
  localparam logic [2:0] PCSRC_JR    = 3'd3;
  localparam logic [2:0] PCSRC_ILLOP = 3'd4;
  localparam logic [2:0] PCSRC_XADR  = 3'd5;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HELD  = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;     // fetch address + 4
    logic [31:0] instr;  // 0 = bubble
  } ifid_t;

  // Sequential increment never touches the kernel bit.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pipeline_IFID_reg.sv
// pipeline_IFID_reg -- IF/ID pipeline register.
//   clk, reset : clock, async active-low reset
//   load       : capture d (has priority over bubble)
//   bubble     : clear instruction, keep pc
//   d / q      : {pc, instr} payload in / out
// Neither load nor bubble -> hold (stall).
module pipeline_IFID_reg
  import pipeline_if_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= {RESET_VEC, 32'h0};
    end else if (load) begin
      q <= d;
    end else if (bubble) begin
      q.instr <= 32'h0;
    end
  end

endmodule

// File: rtl/pipeline_if.sv
// pipeline_if -- instruction fetch stage with stall/redirect handling.
//   clk, reset         : clock, async active-low reset
//   Stall              : load-use hold; freezes PC, IF/ID and skid buffer
//   PCSrc, IDcontrol_* : redirect controls from ID
//   ConBA, JT, PCout   : branch / jump-field / register targets
//   imem_req/addr      : fetch request, address stable until ready
//   imem_ready/rdata   : fetch response (same-cycle ready allowed)
//   ID_PC/ID_instruction : IF/ID register contents (instr 0 = bubble)
//   IF_busy            : fetch outstanding (WAIT)
module pipeline_if
  import pipeline_if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [2:0]  PCSrc,
  input  logic        IDcontrol_Branch,
  input  logic        IDcontrol_Jump,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] PCout,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_instruction,
  output logic        IF_busy
);

  if_state_e   state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] skid, skid_n;
  logic        kill, kill_n;
  logic [31:0] hold_addr, hold_addr_n;
  logic [31:0] pc_seq;
  logic        redirect;
  logic [31:0] target;
  logic        ifid_load, ifid_bubble;
  ifid_t       ifid_d, ifid_q;

  assign pc_seq = pc_incr(pc);

  assign redirect = !Stall && (IDcontrol_Branch || IDcontrol_Jump ||
                               PCSrc == PCSRC_ILLOP || PCSrc == PCSRC_XADR);

  always_comb begin
    target = ConBA;
    if (PCSrc == PCSRC_XADR)       target = XADR_VEC;
    else if (PCSrc == PCSRC_ILLOP) target = ILLOP_VEC;
    else if (IDcontrol_Jump)       target = (PCSrc == PCSRC_JR) ? PCout
                                          : {ifid_q.pc[31:28], JT, 2'b00};
  end

  // While a killed request is outstanding the PC already holds the redirect
  // target; the bus keeps seeing the original address until it completes.
  assign imem_req  = (state != HELD);
  assign imem_addr = kill ? hold_addr : pc;
  assign IF_busy   = (state == WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_VEC;
      skid      <= 32'h0;
      kill      <= 1'b0;
      hold_addr <= RESET_VEC;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      skid      <= skid_n;
      kill      <= kill_n;
      hold_addr <= hold_addr_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    skid_n      = skid;
    kill_n      = kill;
    hold_addr_n = hold_addr;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_d      = '{pc: pc_seq, instr: imem_rdata};

    case (state)
      FETCH, WAIT: begin
        if (kill) begin
          // Outstanding word belongs to a squashed path: drop it on arrival.
          if (imem_ready) begin
            kill_n  = 1'b0;
            state_n = FETCH;
          end
          if (redirect) pc_n = target;
          ifid_bubble = !Stall;
        end else if (Stall) begin
          if (imem_ready) begin
            skid_n  = imem_rdata;
            state_n = HELD;
          end else begin
            state_n = WAIT;
          end
        end else if (redirect) begin
          ifid_bubble = 1'b1;
          pc_n        = target;
          if (imem_ready) begin
            state_n = FETCH;
          end else begin
            // Request not yet accepted: keep the address stable, fetch
            // the target once the stale word has come back.
            kill_n      = 1'b1;
            hold_addr_n = pc;
            state_n     = WAIT;
          end
        end else if (imem_ready) begin
          ifid_load = 1'b1;
          pc_n      = pc_seq;
          state_n   = FETCH;
        end else begin
          ifid_bubble = 1'b1;
          state_n     = WAIT;
        end
      end

      HELD: begin
        if (!Stall) begin
          if (redirect) begin
            ifid_bubble = 1'b1;
            pc_n        = target;
          end else begin
            ifid_load    = 1'b1;
            ifid_d.instr = skid;
            pc_n         = pc_seq;
          end
          state_n = FETCH;
        end
      end

      default: state_n = FETCH;
    endcase
  end

  pipeline_IFID_reg u_ifid (
    .clk    (clk),
    .reset  (reset),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign ID_PC          = ifid_q.pc;
  assign ID_instruction = ifid_q.instr;

endmodule

// File: tb/tb_pipeline_if.sv
module tb_pipeline_if;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic [2:0]  PCSrc = 3'd0;
  logic        IDcontrol_Branch = 1'b0;
  logic        IDcontrol_Jump = 1'b0;
  logic [31:0] ConBA = 32'h0;
  logic [25:0] JT = 26'h0;
  logic [31:0] PCout = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ID_PC;
  logic [31:0] ID_instruction;
  logic        IF_busy;

  pipeline_if dut (
    .clk(clk), .reset(reset), .Stall(Stall), .PCSrc(PCSrc),
    .IDcontrol_Branch(IDcontrol_Branch), .IDcontrol_Jump(IDcontrol_Jump),
    .ConBA(ConBA), .JT(JT), .PCout(PCout),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ID_PC(ID_PC), .ID_instruction(ID_instruction), .IF_busy(IF_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Reference model: the fetch address, an optional word already in hand
  // (buffered while stalled), an outstanding-request flag and a
  // "squashed request" flag with the address the bus must keep seeing.
  logic [31:0] m_pc, m_buf, m_drop_addr, m_id_pc, m_id_ins;
  bit          m_have_buf, m_waiting, m_drop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h8000_0000; m_id_pc = 32'h8000_0000; m_id_ins = 32'h0;
    m_buf = 32'h0; m_drop_addr = 32'h0;
    m_have_buf = 0; m_waiting = 0; m_drop = 0;
  endtask

  task automatic model_step();
    logic redir, got;
    logic [31:0] tgt, w, nxt;
    nxt   = {m_pc[31], m_pc[30:0] + 31'd4};
    redir = !Stall && (IDcontrol_Branch || IDcontrol_Jump || PCSrc == 3'd4 || PCSrc == 3'd5);
    if (PCSrc == 3'd5)      tgt = 32'h8000_0008;
    else if (PCSrc == 3'd4) tgt = 32'h8000_0004;
    else if (IDcontrol_Jump) tgt = (PCSrc == 3'd3) ? PCout : {m_id_pc[31:28], JT, 2'b00};
    else                    tgt = ConBA;

    if (Stall) begin
      // Everything architectural frozen; only the bus side may progress.
      if (!m_have_buf) begin
        if (!imem_ready) m_waiting = 1;
        else begin
          m_waiting = 0;
          if (m_drop) m_drop = 0;
          else begin m_have_buf = 1; m_buf = imem_rdata; end
        end
      end
    end else if (m_drop) begin
      m_id_ins = 32'h0;
      if (imem_ready) begin m_drop = 0; m_waiting = 0; end
      else m_waiting = 1;
      if (redir) m_pc = tgt;
    end else begin
      got = m_have_buf || imem_ready;
      w   = m_have_buf ? m_buf : imem_rdata;
      if (redir) begin
        m_id_ins = 32'h0;
        if (!got) begin m_drop = 1; m_drop_addr = m_pc; m_waiting = 1; end
        else m_waiting = 0;
        m_pc = tgt;
      end else if (got) begin
        m_id_pc = nxt; m_id_ins = w; m_pc = nxt; m_waiting = 0;
      end else begin
        m_id_ins = 32'h0; m_waiting = 1;
      end
      m_have_buf = 0;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && reset) begin
      chk("m_req",  32'(imem_req), 32'(!m_have_buf));
      chk("m_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
      chk("m_busy", 32'(IF_busy), 32'(m_waiting));
      chk("m_idpc", ID_PC, m_id_pc);
      chk("m_idin", ID_instruction, m_id_ins);
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk({tag, "_busy"}, 32'(IF_busy), 32'd0);
    chk({tag, "_ins"},  ID_instruction, 32'h0);
    chk({tag, "_idpc"}, ID_PC, 32'h8000_0000);
    chk({tag, "_addr"}, imem_addr, 32'h8000_0000);
    @(posedge clk);
    #1 reset = 1'b1;
    chk({tag, "_req1"},  32'(imem_req), 32'd1);
    chk({tag, "_addr1"}, imem_addr, 32'h8000_0000);
  endtask

  initial begin
    imem_ready = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_ins",  ID_instruction, 32'h0);
    chk("rst_idpc", ID_PC, 32'h8000_0000);
    chk("rst_busy", 32'(IF_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cmp_en = 1'b1;

    // Sequential fetch
    chk("seq_addr0", imem_addr, 32'h8000_0000);
    chk("seq_req0", 32'(imem_req), 32'd1);
    imem_rdata = 32'h1111_0000; cyc();
    chk("seq_idpc1", ID_PC, 32'h8000_0004);
    chk("seq_ins1", ID_instruction, 32'h1111_0000);
    chk("seq_addr1", imem_addr, 32'h8000_0004);
    imem_rdata = 32'h2222_0000; cyc();
    chk("seq_addr2", imem_addr, 32'h8000_0008);

    // Taken branch: one bubble
    IDcontrol_Branch = 1; PCSrc = 3'd1; ConBA = 32'h8000_0040; imem_rdata = 32'h3333_0000; cyc();
    chk("br_addr", imem_addr, 32'h8000_0040);
    chk("br_bub", ID_instruction, 32'h0);
    chk("br_idpc", ID_PC, 32'h8000_0008);
    IDcontrol_Branch = 0; PCSrc = 3'd0; imem_rdata = 32'h4444_0000; cyc();
    chk("br_ins", ID_instruction, 32'h4444_0000);
    chk("br_idpc2", ID_PC, 32'h8000_0044);

    // Stall masks a jump for two cycles
    Stall = 1; IDcontrol_Jump = 1; PCSrc = 3'd2; JT = 26'h123; imem_rdata = 32'h5555_0000;
    for (int k = 0; k < 2; k++) begin
      imem_rdata = imem_rdata + 32'h1;
      cyc();
      chk("stj_addr", imem_addr, 32'h8000_0044);
      chk("stj_req", 32'(imem_req), 32'd0);
      chk("stj_ins", ID_instruction, 32'h4444_0000);
      chk("stj_idpc", ID_PC, 32'h8000_0044);
    end
    Stall = 0; cyc();
    chk("stj_tgt", imem_addr, 32'h8000_048C);
    chk("stj_bub", ID_instruction, 32'h0);
    IDcontrol_Jump = 0; PCSrc = 3'd0;

    // Ready together with Stall: word buffered, no refetch
    Stall = 1; imem_ready = 1; imem_rdata = 32'h7777_0000; cyc();
    chk("skid_req", 32'(imem_req), 32'd0);
    Stall = 0; imem_ready = 0; imem_rdata = 32'hDEAD_BEEF; cyc();
    chk("skid_ins", ID_instruction, 32'h7777_0000);
    chk("skid_idpc", ID_PC, 32'h8000_0490);
    chk("skid_addr", imem_addr, 32'h8000_0490);

    // Exception redirect while the fetch is still outstanding
    PCSrc = 3'd5; cyc();
    chk("x_addr1", imem_addr, 32'h8000_0490);
    chk("x_busy1", 32'(IF_busy), 32'd1);
    PCSrc = 3'd0; cyc();
    chk("x_addr2", imem_addr, 32'h8000_0490);
    cyc();
    chk("x_addr3", imem_addr, 32'h8000_0490);
    imem_ready = 1; imem_rdata = 32'hBAD0_BAD0; cyc();
    chk("x_tgt", imem_addr, 32'h8000_0008);
    chk("x_drop", ID_instruction, 32'h0);
    imem_rdata = 32'h8888_0000; cyc();
    chk("x_ins", ID_instruction, 32'h8888_0000);
    chk("x_idpc", ID_PC, 32'h8000_000C);

    // Asynchronous reset in the middle of WAIT
    imem_ready = 0; cyc(); cyc();
    chk("rw_busy", 32'(IF_busy), 32'd1);
    async_reset_check("rw");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int kind;
      imem_rdata = $urandom;
      imem_ready = ($urandom_range(0, 9) < 7);
      Stall      = ($urandom_range(0, 9) < 2);
      kind       = $urandom_range(0, 99);
      kind       = (kind < 75) ? 0 : (kind < 85) ? 1 : (kind < 91) ? 2 :
                   (kind < 95) ? 3 : (kind < 98) ? 4 : 5;
      PCSrc            = 3'(kind);
      IDcontrol_Branch = (kind == 1);
      IDcontrol_Jump   = (kind == 2 || kind == 3);
      ConBA = {1'b1, 29'($urandom), 2'b00};
      PCout = {$urandom_range(0, 1) == 1, 29'($urandom), 2'b00};
      JT    = 26'($urandom);
      cyc();
      if (i == 1500) begin
        imem_ready = 0; Stall = 0; PCSrc = 3'd0;
        IDcontrol_Branch = 0; IDcontrol_Jump = 0;
        async_reset_check("rr");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_if.md
PIPELINE_IF -- requirements
Module: pipeline_IF

Interface
REQ-001 SHALL: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-low reset (reset=0 resets).
REQ-003 SHALL: Stall  in  1  load-use hold from hazard unit; freezes PC and IF/ID.
REQ-004 SHALL: PCSrc  in  3  ID control select: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr, 4 ILLOP, 5 XADR.
REQ-005 SHALL: IDcontrol_Branch  in  1  branch in ID resolved taken.
REQ-006 SHALL: IDcontrol_Jump  in  1  j/jal/jr/jalr in ID.
REQ-007 SHALL: ConBA  in  32  branch target.
REQ-008 SHALL: JT  in  26  jump field.
REQ-009 SHALL: PCout  in  32  jr register target.
REQ-010 SHALL: imem_req  out  1  fetch request; imem_addr held stable while imem_req=1 and imem_ready=0.
REQ-011 SHALL: imem_addr  out  32  fetch address.
REQ-012 SHALL: imem_ready  in  1  imem_rdata valid this cycle; same-cycle ready legal.
REQ-013 SHALL: imem_rdata  in  32  fetched word.
REQ-014 SHALL: ID_PC  out  32  fetch address + 4 of instruction in ID.
REQ-015 SHALL: ID_instruction  out  32  IF/ID instruction; 0 = bubble.
REQ-016 SHALL: IF_busy  out  1  fetch outstanding (state WAIT).

Function
REQ-017 SHALL: Redirect = !Stall & (IDcontrol_Branch | IDcontrol_Jump | PCSrc==4 | PCSrc==5).
REQ-018 SHALL: targets -- branch: ConBA; j: {ID_PC[31:28],JT,2'b00}; jr: PCout; ILLOP: 0x80000004; XADR: 0x80000008; priority XADR > ILLOP > jump > branch.
REQ-019 SHALL: sequential next PC = {PC[31], PC[30:0]+4}; bit 31 (kernel) never changed by increment.
REQ-020 SHALL: FSM states FETCH, WAIT, HELD.
REQ-021 SHALL: FETCH: imem_req=1, imem_addr=PC; ready & !Stall -> IF/ID loads {PC+4, rdata}, PC advances, stay FETCH; ready & Stall -> word to skid buffer, HELD; !ready -> WAIT.
REQ-022 SHALL: WAIT: imem_req=1 same address; on ready behave as FETCH-with-ready.
REQ-023 SHALL: HELD: imem_req=0; when Stall=0 skid word moves to IF/ID, PC advances, -> FETCH.
REQ-024 SHALL: Redirect in FETCH/HELD: skid and current word discarded, IF/ID loads bubble, PC=target next cycle, -> FETCH.
REQ-025 SHALL: Redirect in WAIT with ready=0: target latched, kill flag set, address held; returning word dropped; next cycle fetch target; IF/ID bubble every cycle meanwhile.
REQ-026 SHALL: Stall=1: PC, IF/ID, skid unchanged; Redirect ignored (ID re-evaluates next cycle).
REQ-027 SHALL: no valid word and Stall=0 -> ID_instruction=0, ID_PC unchanged.
REQ-028 SHALL: latency: redirect decided in cycle N -> target fetch issued in N+1; taken branch costs exactly one bubble with ready tied high.

Reset
REQ-029 SHALL: reset=0 async: PC=0x80000000, ID_instruction=0, ID_PC=0x80000000, skid empty, kill=0, state FETCH.
REQ-030 SHALL: reset mid-WAIT abandons outstanding request; first request after release at 0x80000000.

Structure
REQ-031 SHALL: shared package holds PCSrc encodings, RESET_VEC, ILLOP_VEC, XADR_VEC, FSM state type.
REQ-032 SHALL: IF/ID register (load/hold/bubble) as sub-module pipeline_IFID_reg.

Verification
REQ-033 SHALL: reset release, ready=1 -> addrs 0x80000000, 0x80000004, 0x80000008; ID_PC 0x80000004 one cycle after first.
REQ-034 SHALL: IDcontrol_Branch=1, ConBA=0x80000040 -> next imem_addr 0x80000040, one ID_instruction=0 bubble.
REQ-035 SHALL: Stall=1 two cycles with IDcontrol_Jump=1 -> PC/IF/ID frozen, no redirect; Stall=0 -> redirect taken.
REQ-036 SHALL: ready low 3 cycles, PCSrc=5 in cycle 1 -> address held, returned word dropped, next request 0x80000008.
REQ-037 SHALL: ready & Stall same cycle -> HELD, imem_req=0; Stall=0 -> buffered word in ID, no refetch.
REQ-038 SHALL: reset=0 asserted mid-WAIT -> outputs reset immediately, no clock edge needed.
